// File: rtl/arf_access_sequencer.sv
// Control sequencer for the 8-bit address register file (PC, AR, SP).
// Arbitrates jump / stack / AR-load / fetch requests and drives ARF control fields as Moore outputs.
module arf_access_sequencer #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fetch_req,
  output logic       fetch_ack,
  input  logic       stack_req,
  input  logic       stack_op,
  output logic       stack_ack,
  input  logic       jump_req,
  input  logic [7:0] jump_addr,
  output logic       jump_ack,
  input  logic       ar_req,
  input  logic [7:0] ar_data,
  output logic       ar_ack,
  output logic [7:0] arf_I,
  output logic [1:0] arf_OutASel,
  output logic [1:0] arf_OutBSel,
  output logic [1:0] arf_FunSel,
  output logic [2:0] arf_RSel,
  input  logic [7:0] arf_OutA,
  output logic [7:0] mem_addr,
  output logic       mem_addr_valid,
  output logic       busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  localparam logic [1:0] SEL_AR  = 2'b00;
  localparam logic [1:0] SEL_SP  = 2'b01;
  localparam logic [1:0] SEL_PC  = 2'b10;
  localparam logic [1:0] FN_CLR  = 2'b00;
  localparam logic [1:0] FN_LD   = 2'b01;
  localparam logic [1:0] FN_DEC  = 2'b10;
  localparam logic [1:0] FN_INC  = 2'b11;
  localparam logic [2:0] WR_PC   = 3'b100;
  localparam logic [2:0] WR_AR   = 3'b010;
  localparam logic [2:0] WR_SP   = 3'b001;

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_FETCH_RD,
    S_FETCH_INC,
    S_PUSH_DEC,
    S_PUSH_ADDR,
    S_PUSH_DONE,
    S_POP_ADDR,
    S_POP_INC,
    S_LOAD_PC,
    S_LOAD_AR
  } state_t;

  typedef struct packed {
    logic [7:0] i;
    logic [1:0] outa;
    logic [1:0] fun;
    logic [2:0] rsel;
  } arf_ctrl_t;

  state_t     r_state, w_next;
  arf_ctrl_t  w_ctrl;
  logic [3:0] r_starve;
  logic [7:0] r_mem_addr;
  logic       w_starved;
  logic       w_addr_cap;

  assign w_starved = fetch_req && (r_starve == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_ctrl         = '0;
    fetch_ack      = 1'b0;
    stack_ack      = 1'b0;
    jump_ack       = 1'b0;
    ar_ack         = 1'b0;
    mem_addr_valid = 1'b0;
    busy           = 1'b1;
    case (r_state)
      S_INIT: begin
        w_ctrl.fun  = FN_CLR;
        w_ctrl.rsel = WR_PC | WR_AR | WR_SP;
        w_next      = S_IDLE;
      end
      S_IDLE: begin
        busy = 1'b0;
        // Starvation override beats the fixed priority order.
        if (w_starved)      w_next = S_FETCH_RD;
        else if (jump_req)  w_next = S_LOAD_PC;
        else if (stack_req) w_next = stack_op ? S_POP_ADDR : S_PUSH_DEC;
        else if (ar_req)    w_next = S_LOAD_AR;
        else if (fetch_req) w_next = S_FETCH_RD;
        else                w_next = S_IDLE;
      end
      S_FETCH_RD: begin
        w_ctrl.outa = SEL_PC;
        w_next      = S_FETCH_INC;
      end
      S_FETCH_INC: begin
        w_ctrl.fun     = FN_INC;
        w_ctrl.rsel    = WR_PC;
        fetch_ack      = 1'b1;
        mem_addr_valid = 1'b1;
        w_next         = S_IDLE;
      end
      S_PUSH_DEC: begin
        w_ctrl.fun  = FN_DEC;
        w_ctrl.rsel = WR_SP;
        w_next      = S_PUSH_ADDR;
      end
      S_PUSH_ADDR: begin
        w_ctrl.outa = SEL_SP;
        w_next      = S_PUSH_DONE;
      end
      S_PUSH_DONE: begin
        stack_ack      = 1'b1;
        mem_addr_valid = 1'b1;
        w_next         = S_IDLE;
      end
      S_POP_ADDR: begin
        w_ctrl.outa = SEL_SP;
        w_next      = S_POP_INC;
      end
      S_POP_INC: begin
        w_ctrl.fun     = FN_INC;
        w_ctrl.rsel    = WR_SP;
        stack_ack      = 1'b1;
        mem_addr_valid = 1'b1;
        w_next         = S_IDLE;
      end
      S_LOAD_PC: begin
        w_ctrl.fun  = FN_LD;
        w_ctrl.rsel = WR_PC;
        w_ctrl.i    = jump_addr;
        jump_ack    = 1'b1;
        w_next      = S_IDLE;
      end
      S_LOAD_AR: begin
        w_ctrl.fun  = FN_LD;
        w_ctrl.rsel = WR_AR;
        w_ctrl.i    = ar_data;
        ar_ack      = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_INIT;
    endcase
  end

  // Counts IDLE arbitrations a pending fetch lost; saturates so the override sticks until granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (r_state == S_IDLE && fetch_req) begin
      if (w_next == S_FETCH_RD)    r_starve <= '0;
      else if (r_starve != LIMIT)  r_starve <= r_starve + 4'd1;
    end
  end

  assign w_addr_cap = (r_state == S_FETCH_RD) || (r_state == S_PUSH_ADDR) ||
                      (r_state == S_POP_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_mem_addr <= '0;
    else if (w_addr_cap) r_mem_addr <= arf_OutA;
  end

  assign mem_addr    = r_mem_addr;
  assign arf_I       = w_ctrl.i;
  assign arf_OutASel = w_ctrl.outa;
  assign arf_OutBSel = 2'b00;
  assign arf_FunSel  = w_ctrl.fun;
  // The FSM sits in INIT during reset; keep the clear-all write off until reset is released.
  assign arf_RSel    = rst_n ? w_ctrl.rsel : 3'b000;

  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({fetch_ack, stack_ack, jump_ack, ar_ack}));
  a_valid_ack: assert property (@(posedge clk) disable iff (!rst_n)
    mem_addr_valid == (fetch_ack || stack_ack));

endmodule

// File: tb/tb_arf_access_sequencer.sv
// Randomized scoreboard bench for arf_access_sequencer with a behavioural ARF and reference model.
module tb_arf_access_sequencer;
  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fetch_req = 0, stack_req = 0, stack_op = 0, jump_req = 0, ar_req = 0;
  logic [7:0] jump_addr = 0, ar_data = 0;
  logic       fetch_ack, stack_ack, jump_ack, ar_ack;
  logic [7:0] arf_I, arf_OutA, mem_addr;
  logic [1:0] arf_OutASel, arf_OutBSel, arf_FunSel;
  logic [2:0] arf_RSel;
  logic       mem_addr_valid, busy;

  always #5 clk = ~clk;

  arf_access_sequencer #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack),
    .stack_req(stack_req), .stack_op(stack_op), .stack_ack(stack_ack),
    .jump_req(jump_req), .jump_addr(jump_addr), .jump_ack(jump_ack),
    .ar_req(ar_req), .ar_data(ar_data), .ar_ack(ar_ack),
    .arf_I(arf_I), .arf_OutASel(arf_OutASel), .arf_OutBSel(arf_OutBSel),
    .arf_FunSel(arf_FunSel), .arf_RSel(arf_RSel), .arf_OutA(arf_OutA),
    .mem_addr(mem_addr), .mem_addr_valid(mem_addr_valid), .busy(busy)
  );

  // Behavioural ARF; starts with junk so INIT's clear is observable.
  logic [7:0] pc = 8'h5A, ar = 8'hA5, sp = 8'h3C;

  function automatic logic [7:0] alu(input logic [7:0] v, input logic [1:0] fs, input logic [7:0] d);
    case (fs)
      2'b00:   return 8'h00;
      2'b01:   return d;
      2'b10:   return v - 8'd1;
      default: return v + 8'd1;
    endcase
  endfunction

  always_comb begin
    case (arf_OutASel)
      2'b00:   arf_OutA = ar;
      2'b01:   arf_OutA = sp;
      2'b10:   arf_OutA = pc;
      default: arf_OutA = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (arf_RSel[2]) pc <= alu(pc, arf_FunSel, arf_I);
    if (arf_RSel[1]) ar <= alu(ar, arf_FunSel, arf_I);
    if (arf_RSel[0]) sp <= alu(sp, arf_FunSel, arf_I);
  end

  // kind: 0 fetch, 1 stack, 2 jump, 3 AR load
  typedef struct {
    int         kind;
    int         lat;
    logic [7:0] addr, pc, ar, sp;
  } exp_t;

  exp_t       q[$];
  exp_t       pe;
  bit         pend = 0;
  int         gap = 0;
  int         tests = 0, fails = 0;
  logic [7:0] m_pc = 0, m_ar = 0, m_sp = 0;
  int         m_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic mon_step();
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      gap  = 0;
      pend = 0;
      return;
    end
    if (busy) gap++; else gap = 0;
    if (pend) begin
      pend = 0;
      chk("pc_after", 32'(pc), 32'(pe.pc));
      chk("ar_after", 32'(ar), 32'(pe.ar));
      chk("sp_after", 32'(sp), 32'(pe.sp));
      chk("idle_after_ack", 32'(busy), 32'(0));
    end
    if (fetch_ack || stack_ack || jump_ack || ar_ack || mem_addr_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", 32'({fetch_ack, stack_ack, jump_ack, ar_ack, mem_addr_valid}), 32'(0));
      end else begin
        e = q.pop_front();
        chk("ack_kind", 32'({fetch_ack, stack_ack, jump_ack, ar_ack}), 32'(4'b1000 >> e.kind));
        chk("mem_addr_valid", 32'(mem_addr_valid), 32'(e.kind < 2));
        if (e.kind < 2) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("ack_latency", 32'(gap), 32'(e.lat));
        chk("outb_sel", 32'(arf_OutBSel), 32'(0));
        pe   = e;
        pend = 1;
      end
    end
  endtask

  // Predicts the grant sequence for a set of held requests, then drives them until acked.
  task automatic run_round(input int nf, input int ns, input int nj, input int na,
                           input logic op, input logic [7:0] ja, input logic [7:0] ad);
    int   r[4];
    int   w, c;
    exp_t e;
    r = '{nf, ns, nj, na};
    while (r[0] + r[1] + r[2] + r[3] > 0) begin
      if (r[0] > 0 && m_cnt == LIMIT) w = 0;
      else if (r[2] > 0)              w = 2;
      else if (r[1] > 0)              w = 1;
      else if (r[3] > 0)              w = 3;
      else                            w = 0;
      if (w == 0)                          m_cnt = 0;
      else if (r[0] > 0 && m_cnt < LIMIT)  m_cnt++;
      e.kind = w;
      e.addr = 8'h00;
      case (w)
        0: begin e.addr = m_pc; m_pc = m_pc + 8'd1; e.lat = 2; end
        1: if (op) begin e.addr = m_sp; m_sp = m_sp + 8'd1; e.lat = 2; end
           else    begin m_sp = m_sp - 8'd1; e.addr = m_sp; e.lat = 3; end
        2: begin m_pc = ja; e.lat = 1; end
        default: begin m_ar = ad; e.lat = 1; end
      endcase
      e.pc = m_pc; e.ar = m_ar; e.sp = m_sp;
      q.push_back(e);
      r[w]--;
    end
    c = 0;
    do begin @(negedge clk); c++; end while (busy && c < 100);
    r = '{nf, ns, nj, na};
    fetch_req = (nf > 0); stack_req = (ns > 0); stack_op = op;
    jump_req = (nj > 0);  jump_addr = ja;       ar_req = (na > 0); ar_data = ad;
    c = 0;
    while (r[0] + r[1] + r[2] + r[3] > 0 && c < 400) begin
      @(negedge clk);
      c++;
      if (fetch_ack && r[0] > 0) begin r[0]--; if (r[0] == 0) fetch_req = 0; end
      if (stack_ack && r[1] > 0) begin r[1]--; if (r[1] == 0) stack_req = 0; end
      if (jump_ack  && r[2] > 0) begin r[2]--; if (r[2] == 0) jump_req  = 0; end
      if (ar_ack    && r[3] > 0) begin r[3]--; if (r[3] == 0) ar_req    = 0; end
    end
    if (r[0] + r[1] + r[2] + r[3] > 0) begin
      chk("round_timeout_left", 32'(r[0] + r[1] + r[2] + r[3]), 32'(0));
      fetch_req = 0; stack_req = 0; jump_req = 0; ar_req = 0;
    end
  endtask

  initial begin
    int nf, ns, nj, na;
    fork
      forever mon_step();
    join_none

    // Reset values while rst_n is low
    @(negedge clk);
    chk("rst_busy",     32'(busy),           32'(1));
    chk("rst_rsel",     32'(arf_RSel),       32'(0));
    chk("rst_funsel",   32'(arf_FunSel),     32'(0));
    chk("rst_outasel",  32'(arf_OutASel),    32'(0));
    chk("rst_I",        32'(arf_I),          32'(0));
    chk("rst_mem_addr", 32'(mem_addr),       32'(0));
    chk("rst_valid",    32'(mem_addr_valid), 32'(0));
    chk("rst_acks",     32'({fetch_ack, stack_ack, jump_ack, ar_ack}), 32'(0));
    rst_n = 1'b1;
    #1;
    chk("init_rsel",   32'(arf_RSel),   32'(3'b111));
    chk("init_funsel", 32'(arf_FunSel), 32'(0));
    chk("init_busy",   32'(busy),       32'(1));
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'(0));
    chk("init_pc",   32'(pc),   32'(0));
    chk("init_ar",   32'(ar),   32'(0));
    chk("init_sp",   32'(sp),   32'(0));

    // Directed scenarios
    run_round(1, 0, 0, 0, 1'b0, 8'h00, 8'h00);        // fetch at PC 0
    run_round(1, 0, 1, 0, 1'b0, 8'h40, 8'h00);        // jump 0x40 then fetch
    run_round(0, 1, 0, 0, 1'b0, 8'h00, 8'h00);        // push at SP 0 -> 0xFF
    run_round(0, 1, 0, 0, 1'b1, 8'h00, 8'h00);        // pop at SP 0xFF -> 0x00
    run_round(1, 1, 1, 1, 1'b1, 8'h7E, 8'h12);        // all four at once
    run_round(0, 0, 1, 0, 1'b0, 8'hFF, 8'h00);        // PC 0xFF ...
    run_round(1, 0, 0, 0, 1'b0, 8'h00, 8'h00);        // ... fetch wraps to 0x00
    run_round(1, 6, 0, 0, 1'b0, 8'h00, 8'h00);        // starvation override

    // Randomized rounds
    for (int i = 0; i < 30; i++) begin
      nf = $urandom_range(0, 2); ns = $urandom_range(0, 3);
      nj = $urandom_range(0, 2); na = $urandom_range(0, 2);
      if (nf + ns + nj + na == 0) nf = 1;
      run_round(nf, ns, nj, na, 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // Reset mid-push: abandon without ack, INIT wipes the decremented SP
    do @(negedge clk); while (busy);
    stack_req = 1; stack_op = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("push_addr_outasel", 32'(arf_OutASel), 32'(2'b01));
    chk("push_addr_sp_dec",  32'(sp),          32'(m_sp - 8'd1));
    rst_n = 1'b0; stack_req = 0;
    #1;
    chk("midrst_busy",     32'(busy),     32'(1));
    chk("midrst_rsel",     32'(arf_RSel), 32'(0));
    chk("midrst_outasel",  32'(arf_OutASel), 32'(0));
    chk("midrst_mem_addr", 32'(mem_addr), 32'(0));
    chk("midrst_acks",     32'({fetch_ack, stack_ack, jump_ack, ar_ack, mem_addr_valid}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reinit_rsel", 32'(arf_RSel), 32'(3'b111));
    @(negedge clk);
    chk("reinit_busy", 32'(busy), 32'(0));
    chk("reinit_sp",   32'(sp),   32'(0));
    chk("reinit_pc",   32'(pc),   32'(0));
    m_pc = 0; m_ar = 0; m_sp = 0; m_cnt = 0;
    run_round(1, 1, 0, 1, 1'b0, 8'h00, 8'h5C);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
